// File: rtl/bram_responder.sv
// rtl/bram_responder.sv - BRAM request/response adapter with 2-entry response FIFO; optional write ack via macro BRAM_RESPONDER_WRITE_ACK_EN
module bram_responder #(
    parameter int P_DATA_WIDTH    = 16,
    parameter int P_ADDRESS_WIDTH = 10
) (
    input  logic                       I_CLK,
    input  logic                       I_RESET,
    input  logic                       I_REQ_VALID,
    output logic                       O_REQ_READY,
    input  logic                       I_REQ_WRITE,
    input  logic [P_ADDRESS_WIDTH-1:0] I_REQ_ADDRESS,
    input  logic [P_DATA_WIDTH-1:0]    I_REQ_DATA,
    output logic                       O_RESP_VALID,
    input  logic                       I_RESP_READY,
    output logic [P_DATA_WIDTH-1:0]    O_RESP_DATA,
    output logic                       O_RESP_WRITE,
    output logic [P_ADDRESS_WIDTH-1:0] O_BRAM_ADDRESS,
    output logic [P_DATA_WIDTH-1:0]    O_BRAM_DATA,
    output logic                       O_BRAM_WRITE_ENABLE,
    input  logic [P_DATA_WIDTH-1:0]    I_BRAM_DATA
);

    logic                    fire;
    logic                    pop;
    logic                    push;
    logic                    resp_fire;
    logic [1:0]              occupancy;
    logic [1:0]              count_q, count_d;
    logic                    inflight_q, inflight_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [P_DATA_WIDTH-1:0] fifo_data_q [0:1];
    logic [P_DATA_WIDTH-1:0] push_data;

    // Occupancy counts the read in flight so a slot is always reserved for it
    assign occupancy    = count_q + {1'b0, inflight_q};
    assign O_RESP_VALID = ~I_RESET & (count_q != 2'd0);
    assign pop          = O_RESP_VALID & I_RESP_READY;
    assign O_REQ_READY  = ~I_RESET & ((occupancy < 2'd2) | pop);
    assign fire         = I_REQ_VALID & O_REQ_READY;
    assign push         = inflight_q;

    assign O_BRAM_ADDRESS      = I_REQ_ADDRESS;
    assign O_BRAM_DATA         = I_REQ_DATA;
    assign O_BRAM_WRITE_ENABLE = fire & I_REQ_WRITE & ~I_RESET;
    assign O_RESP_DATA         = fifo_data_q[rd_ptr_q];

`ifdef BRAM_RESPONDER_WRITE_ACK_EN
    logic                    inflight_tag_q;
    logic [P_DATA_WIDTH-1:0] inflight_wdata_q;
    logic                    fifo_tag_q [0:1];

    assign resp_fire    = fire;
    assign push_data    = inflight_tag_q ? inflight_wdata_q : I_BRAM_DATA;
    assign O_RESP_WRITE = fifo_tag_q[rd_ptr_q];

    // Capture the write data and tag of the accepted request, and store tags alongside FIFO data
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            inflight_tag_q   <= 1'b0;
            inflight_wdata_q <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_tag_q[i] <= 1'b0;
            end
        end else begin
            if (fire) begin
                inflight_tag_q   <= I_REQ_WRITE;
                inflight_wdata_q <= I_REQ_DATA;
            end
            if (push) begin
                fifo_tag_q[wr_ptr_q] <= inflight_tag_q;
            end
        end
    end
`else
    assign resp_fire    = fire & ~I_REQ_WRITE;
    assign push_data    = I_BRAM_DATA;
    assign O_RESP_WRITE = 1'b0;
`endif

    // Next-state: in-flight lasts one cycle, count tracks push minus pop, 1-bit pointers wrap
    always_comb begin
        inflight_d = resp_fire;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop;
    end

    // State and FIFO storage; reset drops everything in flight or buffered
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
            end
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule

// File: tb/tb_bram_responder.sv
// tb/tb_bram_responder.sv - scoreboard bench for bram_responder with BRAM model and reference memory
module tb_bram_responder;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          I_CLK = 1'b0;
    logic          I_RESET;
    logic          I_REQ_VALID;
    logic          O_REQ_READY;
    logic          I_REQ_WRITE;
    logic [AW-1:0] I_REQ_ADDRESS;
    logic [DW-1:0] I_REQ_DATA;
    logic          O_RESP_VALID;
    logic          I_RESP_READY;
    logic [DW-1:0] O_RESP_DATA;
    logic          O_RESP_WRITE;
    logic [AW-1:0] O_BRAM_ADDRESS;
    logic [DW-1:0] O_BRAM_DATA;
    logic          O_BRAM_WRITE_ENABLE;
    logic [DW-1:0] I_BRAM_DATA;

    bram_responder #(.P_DATA_WIDTH(DW), .P_ADDRESS_WIDTH(AW)) dut (
        .I_CLK(I_CLK),
        .I_RESET(I_RESET),
        .I_REQ_VALID(I_REQ_VALID),
        .O_REQ_READY(O_REQ_READY),
        .I_REQ_WRITE(I_REQ_WRITE),
        .I_REQ_ADDRESS(I_REQ_ADDRESS),
        .I_REQ_DATA(I_REQ_DATA),
        .O_RESP_VALID(O_RESP_VALID),
        .I_RESP_READY(I_RESP_READY),
        .O_RESP_DATA(O_RESP_DATA),
        .O_RESP_WRITE(O_RESP_WRITE),
        .O_BRAM_ADDRESS(O_BRAM_ADDRESS),
        .O_BRAM_DATA(O_BRAM_DATA),
        .O_BRAM_WRITE_ENABLE(O_BRAM_WRITE_ENABLE),
        .I_BRAM_DATA(I_BRAM_DATA)
    );

    always #5 I_CLK = ~I_CLK;

    typedef struct {
        logic [DW-1:0] data;
        logic          tag;
        int            k;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] bram_mem [0:DEPTH-1];
    logic [DW-1:0] ref_mem  [0:DEPTH-1];
    int            checks   = 0;
    int            failures = 0;
    int            edge_cnt = 0;
    bit            mon_en   = 1'b0;
    bit            hold_pending = 1'b0;
    logic [DW-1:0] hold_data;
    logic          hold_tag;
    int            occ;
    logic          exp_valid, exp_pop, exp_ready, exp_fire;
    exp_t          e;

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(32'h0303 + a * 32'h0101);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous BRAM: write on enable, registered read one cycle after the address
    always @(posedge I_CLK) begin
        if (O_BRAM_WRITE_ENABLE === 1'b1) bram_mem[O_BRAM_ADDRESS] <= O_BRAM_DATA;
        I_BRAM_DATA <= bram_mem[O_BRAM_ADDRESS];
    end

    always @(posedge I_CLK) edge_cnt <= edge_cnt + 1;

    // Monitor: outstanding accepted requests form the occupancy; responses pop in order
    always @(negedge I_CLK) begin
        if (mon_en) begin
            occ = sb.size();
            exp_valid = 1'b0;
            if (!I_RESET && occ > 0) exp_valid = (edge_cnt >= sb[0].k + 1);
            chk("resp_valid", O_RESP_VALID, exp_valid);
            if (hold_pending && O_RESP_VALID) begin
                chk("hold_data", O_RESP_DATA, hold_data);
                chk("hold_tag", O_RESP_WRITE, hold_tag);
            end
            exp_pop = exp_valid && I_RESP_READY;
            if (exp_pop) begin
                e = sb.pop_front();
                chk("resp_data", O_RESP_DATA, e.data);
                chk("resp_write", O_RESP_WRITE, e.tag);
            end
            exp_ready = !I_RESET && (occ < 2 || exp_pop);
            chk("req_ready", O_REQ_READY, exp_ready);
            exp_fire = I_REQ_VALID && exp_ready;
            chk("bram_we", O_BRAM_WRITE_ENABLE, exp_fire && I_REQ_WRITE);
            chk("bram_addr", O_BRAM_ADDRESS, I_REQ_ADDRESS);
            chk("bram_wdata", O_BRAM_DATA, I_REQ_DATA);
            if (exp_fire) begin
                if (I_REQ_WRITE) begin
                    ref_mem[I_REQ_ADDRESS] = I_REQ_DATA;
`ifdef BRAM_RESPONDER_WRITE_ACK_EN
                    sb.push_back('{I_REQ_DATA, 1'b1, edge_cnt + 1});
`endif
                end else begin
                    sb.push_back('{ref_mem[I_REQ_ADDRESS], 1'b0, edge_cnt + 1});
                end
            end
            hold_pending = O_RESP_VALID && !I_RESP_READY && !I_RESET;
            hold_data    = O_RESP_DATA;
            hold_tag     = O_RESP_WRITE;
            if (I_RESET) begin
                sb.delete();
                hold_pending = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic idle(input int n);
        I_REQ_VALID = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit acc = 1'b0;
        I_REQ_VALID   = 1'b1;
        I_REQ_WRITE   = w;
        I_REQ_ADDRESS = a;
        I_REQ_DATA    = d;
        for (int n = 0; n < 40 && !acc; n++) begin
            @(negedge I_CLK);
            acc = O_REQ_READY;
            step();
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: request addr %0d never accepted", a);
        end
        I_REQ_VALID = 1'b0;
    endtask

    initial begin
        I_RESET = 1'b1; I_REQ_VALID = 1'b0; I_REQ_WRITE = 1'b0;
        I_REQ_ADDRESS = '0; I_REQ_DATA = '0; I_RESP_READY = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bram_mem[i] = init_val(i);
            ref_mem[i]  = init_val(i);
        end
        step();
        mon_en = 1'b1;
        step();
        I_RESET = 1'b0;
        @(negedge I_CLK);
        chk("rst_resp_data", O_RESP_DATA, 0);
        chk("rst_resp_write", O_RESP_WRITE, 0);
        chk("rst_resp_valid", O_RESP_VALID, 0);
        step();

        // Read of address 0 after reset
        I_RESP_READY = 1'b1;
        send(1'b0, 10'd0, 16'h0);
        idle(4);

        // Write then immediate read of the top address
        send(1'b1, 10'd1023, 16'h00AA);
        send(1'b0, 10'd1023, 16'h0);
        idle(4);

        // Back-to-back reads with consumer always ready
        send(1'b0, 10'd1, 16'h0);
        send(1'b0, 10'd2, 16'h0);
        send(1'b0, 10'd1021, 16'h0);
        idle(5);

        // Backpressure: two accepted, third stalls until the first pop
        I_RESP_READY = 1'b0;
        send(1'b0, 10'd10, 16'h0);
        send(1'b0, 10'd11, 16'h0);
        I_REQ_VALID = 1'b1; I_REQ_WRITE = 1'b0; I_REQ_ADDRESS = 10'd12;
        repeat (3) begin
            @(negedge I_CLK);
            chk("stall_ready", O_REQ_READY, 0);
            step();
        end
        I_RESP_READY = 1'b1;
        @(negedge I_CLK);
        chk("release_ready", O_REQ_READY, 1);
        chk("release_pop", O_RESP_VALID, 1);
        step();
        idle(5);

        // Reset with buffered responses and a pending write that must not land
        I_RESP_READY = 1'b0;
        send(1'b0, 10'd5, 16'h0);
        send(1'b0, 10'd6, 16'h0);
        I_REQ_VALID = 1'b1; I_REQ_WRITE = 1'b0; I_REQ_ADDRESS = 10'd7;
        step();
        I_RESET = 1'b1; I_REQ_WRITE = 1'b1; I_REQ_ADDRESS = 10'd500; I_REQ_DATA = 16'hFFFF;
        step();
        I_RESET = 1'b0; I_REQ_VALID = 1'b0;
        @(negedge I_CLK);
        chk("post_rst_valid", O_RESP_VALID, 0);
        chk("post_rst_data", O_RESP_DATA, 0);
        step();
        I_RESP_READY = 1'b1;
        send(1'b0, 10'd500, 16'h0);
        idle(4);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            I_RESET       = ($urandom_range(0, 79) == 0);
            I_REQ_VALID   = ($urandom_range(0, 3) != 0);
            I_REQ_WRITE   = ($urandom_range(0, 2) == 0);
            I_REQ_ADDRESS = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            I_REQ_DATA    = DW'($urandom);
            I_RESP_READY  = ($urandom_range(0, 3) != 0);
            step();
        end

        I_RESET = 1'b0;
        I_RESP_READY = 1'b1;
        idle(10);
        chk("drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
